capture_trigger: RTL and testbench



---
 rtl/capture_pkg.sv | 15 +
 rtl/key_debounce.sv | 67 ++++++
 rtl/capture_trigger.sv | 137 +++++++++++++
 tb/tb_capture_trigger.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture-trigger path (also used by the frame-grab controller).
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_DELAY     = 3'd2,
        ST_READY     = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_HIBERNATE = 3'd5
    } capture_state_e;

    localparam int unsigned CAPTURE_DEFAULT_DELAY = 32'h0005_0000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser for the raw shutter key plus a consecutive-sample qualifier
// that flips a stable level after DEB_CYCLES matching samples.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    input  logic restart_i,
    input  logic restart_lvl_i,
    output logic key_s_o,
    output logic key_stable_n_o,
    output logic press_evt_o,
    output logic release_evt_o
);

    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             differ;
    logic             hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign differ = (sync2_q != stable_q);
    assign hit    = differ && (cnt_q == DEB_W'(DEB_CYCLES - 1));

    // restart lets the sequencer re-qualify a level from scratch, whatever was seen before
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (restart_i) begin
            stable_d = restart_lvl_i;
            cnt_d    = '0;
        end else if (!differ) begin
            cnt_d = '0;
        end else if (hit) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
    end

    assign key_s_o        = sync2_q;
    assign key_stable_n_o = stable_q;
    assign press_evt_o    = hit && !sync2_q;
    assign release_evt_o  = hit && sync2_q;

endmodule

// File: rtl/capture_trigger.sv
// Shutter-key capture sequencer: debounce, settle delay, then a burst of ready strobes.
// CAPTURE_AUTO_REARM_EN: re-arm via RELEASE after a burst; undefined = hibernate until reset.
module capture_trigger
    import capture_pkg::*;
#(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned DELAY      = CAPTURE_DEFAULT_DELAY,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned NUM_SHOTS  = 1,
    parameter int unsigned SHOT_W     = $clog2(NUM_SHOTS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_n,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic [SHOT_W-1:0] shot_idx,
    output logic              done
);

    capture_state_e    state_q;
    capture_state_e    state_d;
    logic [CNT_W-1:0]  dly_q;
    logic [CNT_W-1:0]  dly_d;
    logic [SHOT_W-1:0] shot_q;
    logic [SHOT_W-1:0] shot_d;

    logic key_s;
    logic key_stable_n;
    logic press_evt;
    logic release_evt;
    logic deb_restart;
    logic deb_lvl;
    logic in_burst;
    logic unused_sig;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_n_i       (key_n),
        .restart_i     (deb_restart),
        .restart_lvl_i (deb_lvl),
        .key_s_o       (key_s),
        .key_stable_n_o(key_stable_n),
        .press_evt_o   (press_evt),
        .release_evt_o (release_evt)
    );

    assign unused_sig = key_stable_n ^ release_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            shot_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            shot_q  <= shot_d;
        end
    end

    assign in_burst = (state_q == ST_DEBOUNCE) || (state_q == ST_DELAY) || (state_q == ST_READY);

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        shot_d      = shot_q;
        deb_restart = 1'b0;
        deb_lvl     = 1'b1;
        if (abort && in_burst) begin
            state_d     = ST_IDLE;
            dly_d       = '0;
            shot_d      = '0;
            deb_restart = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!key_s) begin
                        state_d     = ST_DEBOUNCE;
                        deb_restart = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_s) begin
                        state_d = ST_IDLE;
                    end else if (press_evt) begin
                        state_d = ST_DELAY;
                        dly_d   = '0;
                        shot_d  = '0;
                    end
                end
                ST_DELAY: begin
                    if (dly_q == CNT_W'(DELAY)) begin
                        state_d = ST_READY;
                    end else begin
                        dly_d = dly_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (shot_q == SHOT_W'(NUM_SHOTS - 1)) begin
`ifdef CAPTURE_AUTO_REARM_EN
                        // treat the key as held so RELEASE counts only highs seen from here on
                        state_d     = ST_RELEASE;
                        deb_restart = 1'b1;
                        deb_lvl     = 1'b0;
`else
                        state_d = ST_HIBERNATE;
`endif
                    end else begin
                        state_d = ST_DELAY;
                        shot_d  = shot_q + SHOT_W'(1);
                        dly_d   = '0;
                    end
                end
`ifdef CAPTURE_AUTO_REARM_EN
                ST_RELEASE: begin
                    if (release_evt) begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                ST_HIBERNATE: state_d = ST_HIBERNATE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    assign ready    = (state_q == ST_READY);
    assign busy     = in_burst;
    assign done     = (state_q == ST_HIBERNATE) || (state_q == ST_RELEASE);
    assign shot_idx = shot_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Scoreboard bench for capture_trigger: a 1-shot and a 3-shot instance share clock, reset and key.
module tb_capture_trigger;

    localparam int TB_DELAY = 8;
    localparam int TB_DEB   = 4;
`ifdef CAPTURE_AUTO_REARM_EN
    localparam bit REARM = 1'b1;
`else
    localparam bit REARM = 1'b0;
`endif

    typedef struct {
        int cyc;
        int shot;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_n;
    logic       abort3;
    logic       ready1, busy1, done1;
    logic [0:0] shot1;
    logic       ready3, busy3, done3;
    logic [1:0] shot3;

    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    pulse_t q1[$];
    pulse_t q3[$];
    bit     armed1;
    bit     armed3;

    capture_trigger #(
        .CNT_W     (20),
        .DELAY     (TB_DELAY),
        .DEB_CYCLES(TB_DEB),
        .NUM_SHOTS (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .abort   (1'b0),
        .ready   (ready1),
        .busy    (busy1),
        .shot_idx(shot1),
        .done    (done1)
    );

    capture_trigger #(
        .CNT_W     (20),
        .DELAY     (TB_DELAY),
        .DEB_CYCLES(TB_DEB),
        .NUM_SHOTS (3)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .abort   (abort3),
        .ready   (ready3),
        .busy    (busy3),
        .shot_idx(shot3),
        .done    (done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // First strobe follows 2 sync + 1 IDLE + DEB debounce + DELAY+1 settle cycles; period DELAY+2.
    task automatic push_burst(input int inst, input int p, input int n);
        pulse_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc  = p + TB_DEB + TB_DELAY + 4 + i * (TB_DELAY + 2);
            e.shot = i;
            if (inst == 1) q1.push_back(e);
            else           q3.push_back(e);
        end
    endtask

    task automatic pop_check(input int inst, input int shot);
        pulse_t e;
        bit     empty;
        empty = (inst == 1) ? (q1.size() == 0) : (q3.size() == 0);
        n_tests++;
        if (empty) begin
            n_fail++;
            $display("FAIL dut%0d_unexpected_ready: ready at cycle %0d shot_idx %0d, expected no pulse",
                     inst, cyc, shot);
        end else begin
            if (inst == 1) e = q1.pop_front();
            else           e = q3.pop_front();
            if (e.cyc != cyc || e.shot != shot) begin
                n_fail++;
                $display("FAIL dut%0d_pulse: cycle %0d shot_idx %0d, expected cycle %0d shot_idx %0d",
                         inst, cyc, shot, e.cyc, e.shot);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ready1 === 1'b1) pop_check(1, int'(shot1));
        if (ready3 === 1'b1) pop_check(3, int'(shot3));
    end

    task automatic press(input int p);
        wait_to(p);
        key_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        key_n   = 1'b1;
        abort3  = 1'b0;
        armed1  = 1'b1;
        armed3  = 1'b1;

        wait_to(2);
        chk("reset_ready1", int'(ready1), 0);
        chk("reset_busy1",  int'(busy1),  0);
        chk("reset_done1",  int'(done1),  0);
        chk("reset_shot1",  int'(shot1),  0);
        chk("reset_ready3", int'(ready3), 0);
        chk("reset_busy3",  int'(busy3),  0);
        chk("reset_done3",  int'(done3),  0);
        chk("reset_shot3",  int'(shot3),  0);
        wait_to(3);
        reset_n = 1'b1;

        // two-cycle glitch: enters DEBOUNCE, falls back to IDLE
        press(10);
        wait_to(12);
        key_n = 1'b1;
        wait_to(14);
        chk("glitch_debounce_busy3", int'(busy3), 1);
        wait_to(16);
        chk("glitch_idle_busy1", int'(busy1), 0);
        chk("glitch_idle_busy3", int'(busy3), 0);

        // full burst
        press(30);
        push_burst(1, 30, 1);
        push_burst(3, 30, 3);
        armed1 = REARM;
        armed3 = REARM;
        wait_to(37);
        chk("burst_delay_busy3", int'(busy3), 1);
        wait_to(40);
        key_n = 1'b1;
        wait_to(47);
        chk("burst_end_done1", int'(done1), 1);
        chk("burst_end_busy1", int'(busy1), 0);
        wait_to(67);
        chk("burst_end_done3", int'(done3), 1);
        chk("burst_end_busy3", int'(busy3), 0);
        chk("burst_end_shot3", int'(shot3), 2);

        // second press: ignored unless the block re-arms
        press(80);
        if (armed1) push_burst(1, 80, 1);
        if (armed3) push_burst(3, 80, 3);
        armed1 = REARM;
        armed3 = REARM;
        wait_to(90);
        key_n = 1'b1;
        wait_to(125);
        chk("second_press_done3", int'(done3), REARM ? 0 : 1);
        reset_n = 1'b0;
        wait_to(127);
        reset_n = 1'b1;
        armed1 = 1'b1;
        armed3 = 1'b1;

        // asynchronous reset in the middle of DELAY
        press(140);
        wait_to(150);
        key_n = 1'b1;
        chk("pre_reset_busy3", int'(busy3), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_ready1", int'(ready1), 0);
        chk("async_reset_busy1",  int'(busy1),  0);
        chk("async_reset_done1",  int'(done1),  0);
        chk("async_reset_ready3", int'(ready3), 0);
        chk("async_reset_busy3",  int'(busy3),  0);
        chk("async_reset_done3",  int'(done3),  0);
        chk("async_reset_shot3",  int'(shot3),  0);
        wait_to(152);
        reset_n = 1'b1;

        // abort during the second DELAY of the 3-shot burst
        press(170);
        push_burst(1, 170, 1);
        push_burst(3, 170, 1);
        armed1 = REARM;
        wait_to(180);
        key_n = 1'b1;
        wait_to(190);
        chk("abort_pre_shot3", int'(shot3), 1);
        abort3 = 1'b1;
        wait_to(191);
        abort3 = 1'b0;
        chk("abort_busy3", int'(busy3), 0);
        chk("abort_shot3", int'(shot3), 0);
        chk("abort_done3", int'(done3), 0);

        // fresh press after abort, key held well past the burst, then released
        press(210);
        push_burst(3, 210, 3);
        if (armed1) push_burst(1, 210, 1);
        armed1 = REARM;
        armed3 = REARM;
        wait_to(255);
        chk("hold_done3", int'(done3), 1);
        chk("hold_busy3", int'(busy3), 0);
        wait_to(260);
        key_n = 1'b1;
        wait_to(265);
        chk("release_pending_done1", int'(done1), 1);
        chk("release_pending_done3", int'(done3), 1);
        wait_to(266);
        chk("release_done1", int'(done1), REARM ? 0 : 1);
        chk("release_done3", int'(done3), REARM ? 0 : 1);

        // one more press: new pulses only when re-armed
        press(280);
        if (armed1) push_burst(1, 280, 1);
        if (armed3) push_burst(3, 280, 3);
        wait_to(290);
        key_n = 1'b1;
        wait_to(330);

        chk("missing_pulses_dut1", q1.size(), 0);
        chk("missing_pulses_dut3", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
